// File: rtl/md_unit_pkg.sv
// Shared encodings for the execute stage: ALU control, multiply/divide control
// and the md_unit sequencing states.
package md_unit_pkg;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SUB  = 3'b001,
    ALU_AND  = 3'b010,
    ALU_OR   = 3'b011,
    ALU_XOR  = 3'b100,
    ALU_SLT  = 3'b101,
    ALU_SLTU = 3'b110,
    ALU_LUI  = 3'b111
  } alu_ctr_e;

  typedef enum logic [2:0] {
    MD_MULT  = 3'b000,
    MD_MULTU = 3'b001,
    MD_DIV   = 3'b010,
    MD_DIVU  = 3'b011,
    MD_MTHI  = 3'b100,
    MD_MTLO  = 3'b101
  } md_ctr_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_e;

  // Multiply/divide codes are exactly those with the top bit clear.
  function automatic logic is_md_arith(input logic [2:0] code);
    return (code[2] == 1'b0);
  endfunction

endpackage

// File: rtl/md_core.sv
// Combinational multiply/divide datapath producing HI/LO for one operation.
// op[1] selects divide, op[0] selects unsigned.
module md_core #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi_c,
  output logic [WIDTH-1:0] lo_c
);

  localparam int unsigned W2 = 2 * WIDTH;

  logic             sgn;
  logic [W2-1:0]    ext_a;
  logic [W2-1:0]    ext_b;
  logic [W2-1:0]    prod;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH-1:0] q_mag;
  logic [WIDTH-1:0] r_mag;
  logic [WIDTH-1:0] min_neg;
  logic             neg_q;
  logic             neg_r;

  always_comb begin
    sgn     = ~op[0];
    min_neg = {1'b1, {(WIDTH-1){1'b0}}};
    ext_a   = sgn ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
    ext_b   = sgn ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
    prod    = ext_a * ext_b;

    // Divide on magnitudes, then restore signs (quotient toward zero).
    mag_a = (sgn && a[WIDTH-1]) ? -a : a;
    mag_b = (sgn && b[WIDTH-1]) ? -b : b;
    q_mag = (mag_b == '0) ? '0 : (mag_a / mag_b);
    r_mag = (mag_b == '0) ? '0 : (mag_a % mag_b);
    neg_q = sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
    neg_r = sgn & a[WIDTH-1];

    hi_c = prod[W2-1:WIDTH];
    lo_c = prod[WIDTH-1:0];
    if (op[1]) begin
      if (b == '0) begin
        hi_c = a;
        lo_c = '1;
      end else if (sgn && (a == min_neg) && (b == '1)) begin
        hi_c = '0;
        lo_c = min_neg;
      end else begin
        hi_c = neg_r ? -r_mag : r_mag;
        lo_c = neg_q ? -q_mag : q_mag;
      end
    end
  end

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers; the result of an
// accepted op lands in HI/LO exactly MUL_CYCLES/DIV_CYCLES edges later.
module md_unit
  import md_unit_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       MD_CTR,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             busy,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int unsigned MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] res_hi_c;
  logic [WIDTH-1:0] res_lo_c;
  logic             done_c;

  md_core #(.WIDTH(WIDTH)) u_core (
    .op   (op_q),
    .a    (a_q),
    .b    (b_q),
    .hi_c (res_hi_c),
    .lo_c (res_lo_c)
  );

  assign done_c = (state_q == ST_BUSY) && (cnt_q <= CNT_W'(1));

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start && is_md_arith(MD_CTR)) state_d = ST_BUSY;
      ST_BUSY: if (done_c) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Counter, operand capture and HI/LO updates.
  always_comb begin
    cnt_d = cnt_q;
    op_d  = op_q;
    a_d   = a_q;
    b_d   = b_q;
    hi_d  = hi_q;
    lo_d  = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (is_md_arith(MD_CTR)) begin
            op_d  = MD_CTR[1:0];
            a_d   = SrcA;
            b_d   = SrcB;
            cnt_d = MD_CTR[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);
          end else if (MD_CTR == MD_MTHI) begin
            hi_d = SrcA;
          end else if (MD_CTR == MD_MTLO) begin
            lo_d = SrcA;
          end
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (done_c) begin
          cnt_d = '0;
          hi_d  = res_hi_c;
          lo_d  = res_lo_c;
        end
      end
      default: ;
    endcase
  end

  assign busy = (state_q == ST_BUSY);
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Directed self-checking bench for md_unit with default parameters.
module tb_md_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  MD_CTR;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int total = 0;
  int bad   = 0;
  logic [31:0] m_hi = 32'h0;
  logic [31:0] m_lo = 32'h0;

  md_unit #(.WIDTH(32), .MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .MD_CTR (MD_CTR),
    .SrcA   (SrcA),
    .SrcB   (SrcB),
    .busy   (busy),
    .HI     (HI),
    .LO     (LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issue an arith op, scramble inputs while busy, measure busy length.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int n,
                        input logic [31:0] ehi, input logic [31:0] elo);
    int   cyc;
    logic held;
    @(negedge clk);
    start = 1'b1; MD_CTR = op; SrcA = a; SrcB = b;
    @(posedge clk);
    #1;
    start = 1'b0; SrcA = ~a; SrcB = b + 32'd1;
    cyc  = 0;
    held = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy) break;
      cyc++;
      if (HI !== m_hi || LO !== m_lo) held = 1'b0;
    end
    check({tag, "_cyc"}, 64'(cyc), 64'(n));
    check({tag, "_held"}, 64'(held), 64'd1);
    check({tag, "_hi"}, 64'(HI), 64'(ehi));
    check({tag, "_lo"}, 64'(LO), 64'(elo));
    m_hi = ehi;
    m_lo = elo;
  endtask

  // Single-edge request (MTHI/MTLO/no-op); sample right after the edge.
  task automatic one_edge(input string tag, input logic st, input logic [2:0] op,
                          input logic [31:0] a);
    @(negedge clk);
    start = st; MD_CTR = op; SrcA = a; SrcB = 32'h3;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_hi"}, 64'(HI), 64'(m_hi));
    check({tag, "_lo"}, 64'(LO), 64'(m_lo));
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; MD_CTR = 3'b000; SrcA = '0; SrcB = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_hi", 64'(HI), 64'd0);
    check("rst_lo", 64'(LO), 64'd0);

    run_op("mult_neg",  3'b000, 32'hFFFFFFFE, 32'h00000003, 5,  32'hFFFFFFFF, 32'hFFFFFFFA);
    run_op("multu_max", 3'b001, 32'hFFFFFFFF, 32'h00000002, 5,  32'h00000001, 32'hFFFFFFFE);
    run_op("mult_m1sq", 3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 5,  32'h00000000, 32'h00000001);
    run_op("multu_sq",  3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 5,  32'hFFFFFFFE, 32'h00000001);
    run_op("mult_pmax", 3'b000, 32'h7FFFFFFF, 32'h7FFFFFFF, 5,  32'h3FFFFFFF, 32'h00000001);
    run_op("div_neg",   3'b010, 32'hFFFFFFF9, 32'h00000002, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("div_negb",  3'b010, 32'h00000007, 32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD);
    run_op("divu_z",    3'b011, 32'h00000007, 32'h00000000, 10, 32'h00000007, 32'hFFFFFFFF);
    run_op("div_z",     3'b010, 32'hFFFFFFFB, 32'h00000000, 10, 32'hFFFFFFFB, 32'hFFFFFFFF);
    run_op("div_ovf",   3'b010, 32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000);
    run_op("divu_big",  3'b011, 32'h80000000, 32'hFFFFFFFF, 10, 32'h80000000, 32'h00000000);
    run_op("divu_100",  3'b011, 32'h00000064, 32'h00000007, 10, 32'h00000002, 32'h0000000E);

    m_lo = 32'hA5A5A5A5;
    one_edge("mtlo", 1'b1, 3'b101, 32'hA5A5A5A5);
    m_hi = 32'hDEADBEEF;
    one_edge("mthi", 1'b1, 3'b100, 32'hDEADBEEF);
    one_edge("undef6", 1'b1, 3'b110, 32'h11111111);
    one_edge("undef7", 1'b1, 3'b111, 32'h22222222);
    one_edge("nostart", 1'b0, 3'b000, 32'h33333333);
    one_edge("nostart_mt", 1'b0, 3'b100, 32'h44444444);

    // Abort: MULT accepted, MTHI during busy ignored, reset mid-op.
    @(negedge clk);
    start = 1'b1; MD_CTR = 3'b000; SrcA = 32'h3; SrcB = 32'h4;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    start = 1'b1; MD_CTR = 3'b100; SrcA = 32'h1234;
    @(negedge clk);
    check("abort_busy_mid", 64'(busy), 64'd1);
    check("abort_mthi_ign", 64'(HI), 64'(m_hi));
    start = 1'b0; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_hi", 64'(HI), 64'd0);
    check("abort_lo", 64'(LO), 64'd0);
    m_hi = 32'h0; m_lo = 32'h0;
    repeat (8) @(negedge clk);
    check("abort_late_busy", 64'(busy), 64'd0);
    check("abort_late_hi", 64'(HI), 64'd0);
    check("abort_late_lo", 64'(LO), 64'd0);

    // Reset beats a same-edge start.
    m_lo = 32'h00000055;
    one_edge("mtlo2", 1'b1, 3'b101, 32'h00000055);
    @(negedge clk);
    reset = 1'b1; start = 1'b1; MD_CTR = 3'b101; SrcA = 32'h99;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    check("rst_prio_lo", 64'(LO), 64'd0);
    check("rst_prio_busy", 64'(busy), 64'd0);
    m_lo = 32'h0;

    // Operation after reset still works.
    run_op("post_rst", 3'b001, 32'h00010000, 32'h00010000, 5, 32'h00000001, 32'h00000000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/md_unit.md
MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and HI/LO register width.
REQ-002 SHALL have parameter MUL_CYCLES, default 5, busy cycles for multiply ops (>=1).
REQ-003 SHALL have parameter DIV_CYCLES, default 10, busy cycles for divide ops (>=1).
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start  input  1  request strobe; accepted only when busy=0.
REQ-007 SHALL have port MD_CTR  input  3  op: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, others no-op.
REQ-008 SHALL have port SrcA  input  WIDTH  first operand / dividend / MTHI-MTLO data.
REQ-009 SHALL have port SrcB  input  WIDTH  second operand / divisor.
REQ-010 SHALL have port busy  output  1  high while a multiply/divide is in flight.
REQ-011 SHALL have port HI  output  WIDTH  HI register, registered output.
REQ-012 SHALL have port LO  output  WIDTH  LO register, registered output.

Function
REQ-013 SHALL implement a two-state FSM: IDLE, BUSY.
REQ-014 In IDLE, start=1 with MULT/MULTU/DIV/DIVU SHALL capture operands and op, load the cycle counter with MUL_CYCLES or DIV_CYCLES, and enter BUSY; busy SHALL read 1 from the next cycle.
REQ-015 In BUSY the counter SHALL decrement each cycle; on the edge where it reaches 0, HI/LO SHALL be written with the result and the FSM SHALL return to IDLE, busy=0 in the same cycle HI/LO show the new value.
REQ-016 Total latency SHALL be exactly N cycles from accepting edge to HI/LO update (N=MUL_CYCLES or DIV_CYCLES).
REQ-017 MULT SHALL form the signed 2*WIDTH product; MULTU the unsigned one; HI=upper WIDTH bits, LO=lower WIDTH bits.
REQ-018 DIV SHALL divide signed, quotient truncated toward zero into LO, remainder (sign of dividend) into HI; DIVU SHALL do the unsigned equivalent.
REQ-019 Divide by zero SHALL write LO=all ones, HI=SrcA (captured); no exception.
REQ-020 Signed overflow (SrcA = most-negative, SrcB = -1) SHALL write LO=most-negative, HI=0.
REQ-021 MTHI/MTLO with start=1 in IDLE SHALL write SrcA into HI/LO on that edge, busy stays 0, other register unchanged.
REQ-022 start=1 while busy=1 SHALL be ignored entirely (no operand capture, no HI/LO write, no restart).
REQ-023 Undefined MD_CTR codes or start=0 SHALL leave all state unchanged.
REQ-024 Operands SHALL be sampled only at acceptance; SrcA/SrcB changes during BUSY SHALL not affect the result.

Reset
REQ-025 reset=1 on a clock edge SHALL force FSM=IDLE, counter=0, busy=0, HI=0, LO=0, captured operands=0.
REQ-026 reset asserted mid-operation SHALL abort it; the pending result SHALL never be written.
REQ-027 reset SHALL take priority over start on the same edge.

Structure
REQ-028 MD_CTR encodings and FSM state encodings SHALL live in the shared package alongside the ALU_CTR encodings.
REQ-029 Arithmetic (product/quotient/remainder incl. corner cases) SHALL be a combinational sub-module md_core; md_unit SHALL hold FSM, counter, operand and HI/LO registers.

Verification
REQ-030 MULT SrcA=0xFFFFFFFE (-2), SrcB=3 -> after 5 cycles HI=0xFFFFFFFF, LO=0xFFFFFFFA, busy high exactly 5 cycles.
REQ-031 MULTU SrcA=0xFFFFFFFF, SrcB=2 -> HI=0x00000001, LO=0xFFFFFFFE.
REQ-032 DIV SrcA=-7 (0xFFFFFFF9), SrcB=2 -> after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7/0 -> LO=0xFFFFFFFF, HI=7.
REQ-033 DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-034 Start MULT, assert second start (MTHI 0x1234) at cycle 2, then reset at cycle 3 -> MTHI ignored, HI=LO=0, busy=0, no later write.
REQ-035 MTLO 0xA5A5A5A5 in IDLE -> LO=0xA5A5A5A5 next edge, HI unchanged, busy never asserted.
